// File: rtl/multi_edge_counter_pkg.sv
// Shared operation and edge-mode codes for the multi-channel edge counter.
package multi_edge_counter_pkg;

  localparam logic [2:0] INSTR_HOLD    = 3'b000;
  localparam logic [2:0] INSTR_RUN     = 3'b001;
  localparam logic [2:0] INSTR_SETMODE = 3'b011;
  localparam logic [2:0] INSTR_LOAD    = 3'b100;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

endpackage

// File: rtl/multi_edge_counter_edge_channel.sv
// One monitored channel: previous-sample register, edge selection,
// counter with saturate/wrap behaviour and sticky overflow flag.
module edge_channel
  import multi_edge_counter_pkg::*;
#(
  parameter int nBits    = 4,
  parameter int SATURATE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig,
  input  logic             run,
  input  logic             clear,
  input  mode_e            mode,
  output logic [nBits-1:0] count,
  output logic             overflow,
  output logic             hit
);

  logic prev;
  logic rise;
  logic fall;
  logic sel;

  assign rise = ~prev & sig;
  assign fall = prev & ~sig;

  always_comb begin
    sel = 1'b0;
    case (mode)
      MODE_RISE: sel = rise;
      MODE_FALL: sel = fall;
      MODE_BOTH: sel = rise | fall;
      default:   sel = 1'b0;
    endcase
  end

  assign hit = run & sel;

  // prev follows sig under every instruction so HOLD never builds a backlog.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      prev <= sig;
      if (clear) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (hit) begin
        if (&count) begin
          overflow <= 1'b1;
          count    <= (SATURATE != 0) ? count : '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_edge_counter.sv
// Multi-channel edge counter: instruction decode, latched edge mode and the
// anyEdge pulse live here; per-channel counting lives in edge_channel.
module multi_edge_counter
  import multi_edge_counter_pkg::*;
#(
  parameter int nBits     = 4,
  parameter int nChannels = 4,
  parameter int SATURATE  = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2:0]                   instruction,
  input  logic [1:0]                   modeIn,
  input  logic [nChannels-1:0]         sig,
  output logic [nChannels*nBits-1:0]   result,
  output logic [nChannels-1:0]         overflow,
  output logic                         anyEdge
);

  mode_e                mode;
  logic                 is_run;
  logic                 is_load;
  logic                 is_setmode;
  logic [nChannels-1:0] hits;

  assign is_run     = (instruction == INSTR_RUN);
  assign is_load    = (instruction == INSTR_LOAD);
  assign is_setmode = (instruction == INSTR_SETMODE);

  // A new mode only affects counting from the cycle after SETMODE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode <= MODE_RISE;
    end else if (is_setmode) begin
      mode <= mode_e'(modeIn);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anyEdge <= 1'b0;
    end else begin
      anyEdge <= |hits;
    end
  end

  for (genvar k = 0; k < nChannels; k++) begin : g_ch
    edge_channel #(
      .nBits   (nBits),
      .SATURATE(SATURATE)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .sig     (sig[k]),
      .run     (is_run),
      .clear   (is_load),
      .mode    (mode),
      .count   (result[k*nBits +: nBits]),
      .overflow(overflow[k]),
      .hit     (hits[k])
    );
  end

endmodule

// File: tb/tb_multi_edge_counter.sv
// Bench for multi_edge_counter: saturating and wrapping instances driven in
// lockstep, checked every cycle against an arithmetic model plus fixed scenarios.
module tb_multi_edge_counter;
  import multi_edge_counter_pkg::*;

  localparam int NB   = 4;
  localparam int NC   = 8;
  localparam int MAXV = (1 << NB) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [2:0]       instruction;
  logic [1:0]       modeIn;
  logic [NC-1:0]    sig;
  logic [NC*NB-1:0] result_s, result_w;
  logic [NC-1:0]    ovf_s, ovf_w;
  logic             any_s, any_w;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: index 0 = saturating instance, 1 = wrapping instance
  int m_cnt[2][NC];
  bit m_ovf[2][NC];
  bit m_prev[NC];
  int m_mode = 1;
  bit m_any;
  bit m_counted[NC];
  bit m_hit_any;

  multi_edge_counter #(.nBits(NB), .nChannels(NC), .SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .instruction(instruction), .modeIn(modeIn),
    .sig(sig), .result(result_s), .overflow(ovf_s), .anyEdge(any_s)
  );

  multi_edge_counter #(.nBits(NB), .nChannels(NC), .SATURATE(0)) dut_wrap (
    .clock(clock), .reset(reset), .instruction(instruction), .modeIn(modeIn),
    .sig(sig), .result(result_w), .overflow(ovf_w), .anyEdge(any_w)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int d, input int k);
    return (d == 0) ? 32'(result_s[k*NB +: NB]) : 32'(result_w[k*NB +: NB]);
  endfunction

  function automatic logic dut_ovf(input int d, input int k);
    return (d == 0) ? ovf_s[k] : ovf_w[k];
  endfunction

  // behavioural model, evaluated with the inputs the DUT sampled
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NC; k++) begin
        m_prev[k] = 1'b0;
        for (int d = 0; d < 2; d++) begin
          m_cnt[d][k] = 0;
          m_ovf[d][k] = 1'b0;
        end
      end
      m_mode = 1;
      m_any  = 1'b0;
    end else begin
      m_hit_any = 1'b0;
      for (int k = 0; k < NC; k++) begin
        m_counted[k] = ((m_mode == 1 || m_mode == 3) && sig[k] && !m_prev[k]) ||
                       ((m_mode == 2 || m_mode == 3) && !sig[k] && m_prev[k]);
      end
      if (instruction == INSTR_LOAD) begin
        for (int k = 0; k < NC; k++)
          for (int d = 0; d < 2; d++) begin
            m_cnt[d][k] = 0;
            m_ovf[d][k] = 1'b0;
          end
      end else if (instruction == INSTR_RUN) begin
        for (int k = 0; k < NC; k++) begin
          if (m_counted[k]) begin
            m_hit_any = 1'b1;
            for (int d = 0; d < 2; d++) begin
              if (m_cnt[d][k] == MAXV) begin
                m_ovf[d][k] = 1'b1;
                m_cnt[d][k] = (d == 0) ? MAXV : 0;
              end else begin
                m_cnt[d][k] = m_cnt[d][k] + 1;
              end
            end
          end
        end
      end
      if (instruction == INSTR_SETMODE) m_mode = int'(modeIn);
      m_any = m_hit_any;
      for (int k = 0; k < NC; k++) m_prev[k] = sig[k];
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NC; k++) begin
        chk($sformatf("cnt d%0d ch%0d", d, k), dut_cnt(d, k), 32'(m_cnt[d][k]));
        chk($sformatf("ovf d%0d ch%0d", d, k), 32'(dut_ovf(d, k)), 32'(m_ovf[d][k]));
      end
    end
    chk("anyEdge sat", 32'(any_s), 32'(m_any));
    chk("anyEdge wrap", 32'(any_w), 32'(m_any));
  end

  // driver: inputs change at a falling edge, task returns at the next one
  task automatic cyc(input logic [2:0] ins, input logic [1:0] md, input logic [NC-1:0] s);
    instruction = ins;
    modeIn      = md;
    sig         = s;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [2:0] ins;
    reset = 1'b1;
    instruction = INSTR_HOLD;
    modeIn = 2'b00;
    sig = '0;
    #1 reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("reset result", 32'(result_s), 32'h0);
    chk("reset overflow", 32'(ovf_s), 32'h0);
    chk("reset anyEdge", 32'(any_s), 32'h0);
    reset = 1'b1;
    cyc(INSTR_HOLD, 2'b00, 8'h00);

    // rising edges on ch0 with the reset-default mode
    cyc(INSTR_RUN, 2'b00, 8'h00);
    cyc(INSTR_RUN, 2'b00, 8'h01);
    chk("s1 ch0 after first rise", dut_cnt(0, 0), 32'd1);
    chk("s1 anyEdge first pulse", 32'(any_s), 32'd1);
    cyc(INSTR_RUN, 2'b00, 8'h00);
    chk("s1 anyEdge after fall", 32'(any_s), 32'd0);
    cyc(INSTR_RUN, 2'b00, 8'h01);
    chk("s1 anyEdge second pulse", 32'(any_s), 32'd1);
    chk("s1 result vector", 32'(result_s), 32'h0000_0002);
    chk("s1 model ch0", 32'(m_cnt[0][0]), 32'd2);

    // both-edge mode then falling-edge mode on ch1
    cyc(INSTR_LOAD, 2'b00, 8'h00);
    cyc(INSTR_SETMODE, 2'b11, 8'h00);
    for (int i = 0; i < 6; i++) cyc(INSTR_RUN, 2'b00, (i % 2 == 0) ? 8'h02 : 8'h00);
    chk("s2 ch1 both edges", dut_cnt(0, 1), 32'd6);
    cyc(INSTR_SETMODE, 2'b10, 8'h00);
    for (int i = 0; i < 4; i++) cyc(INSTR_RUN, 2'b00, (i % 2 == 0) ? 8'h02 : 8'h00);
    chk("s2 ch1 falling edges", dut_cnt(0, 1), 32'd8);
    chk("s2 model ch1", 32'(m_cnt[1][1]), 32'd8);

    // 17 rising edges on ch2: saturate vs wrap
    cyc(INSTR_LOAD, 2'b00, 8'h00);
    cyc(INSTR_SETMODE, 2'b01, 8'h00);
    for (int i = 0; i < 17; i++) begin
      cyc(INSTR_RUN, 2'b00, 8'h04);
      cyc(INSTR_RUN, 2'b00, 8'h00);
    end
    chk("s3 sat ch2", dut_cnt(0, 2), 32'd15);
    chk("s3 sat overflow", 32'(ovf_s), 32'h04);
    chk("s3 wrap ch2", dut_cnt(1, 2), 32'd1);
    chk("s3 wrap overflow", 32'(ovf_w), 32'h04);

    // ch0 to 5, edges during HOLD ignored, LOAD with a rising edge
    for (int i = 0; i < 5; i++) begin
      cyc(INSTR_RUN, 2'b00, 8'h01);
      cyc(INSTR_RUN, 2'b00, 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(INSTR_HOLD, 2'b00, 8'h01);
      cyc(3'b111, 2'b00, 8'h00);
    end
    cyc(INSTR_RUN, 2'b00, 8'h00);
    cyc(INSTR_RUN, 2'b00, 8'h00);
    chk("s4 ch0 after hold", dut_cnt(0, 0), 32'd5);
    chk("s4 overflow sticky", 32'(ovf_s), 32'h04);
    cyc(INSTR_LOAD, 2'b00, 8'h01);
    chk("s4 ch0 after load", dut_cnt(0, 0), 32'd0);
    chk("s4 overflow after load", 32'(ovf_s), 32'h00);
    cyc(INSTR_RUN, 2'b00, 8'h01);
    chk("s4 no edge after load", dut_cnt(0, 0), 32'd0);

    // asynchronous reset mid-count on ch3
    cyc(INSTR_LOAD, 2'b00, 8'h00);
    for (int i = 0; i < 7; i++) begin
      cyc(INSTR_RUN, 2'b00, 8'h08);
      cyc(INSTR_RUN, 2'b00, 8'h00);
    end
    chk("s5 ch3 before reset", dut_cnt(0, 3), 32'd7);
    instruction = INSTR_RUN;
    sig = 8'h08;
    #2 reset = 1'b0;
    #1;
    chk("s5 result in reset", 32'(result_s), 32'h0);
    chk("s5 overflow in reset", 32'(ovf_s), 32'h0);
    chk("s5 anyEdge in reset", 32'(any_s), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    cyc(INSTR_RUN, 2'b00, 8'h08);
    chk("s5 ch3 after release", dut_cnt(0, 3), 32'd1);

    // all channels rise together
    cyc(INSTR_LOAD, 2'b00, 8'h00);
    cyc(INSTR_RUN, 2'b00, 8'hFF);
    chk("s6 all channels", 32'(result_s), 32'h1111_1111);
    chk("s6 anyEdge high", 32'(any_s), 32'd1);
    cyc(INSTR_RUN, 2'b00, 8'hFF);
    chk("s6 anyEdge one cycle", 32'(any_s), 32'd0);
    chk("s6 counts held", 32'(result_w), 32'h1111_1111);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      if (r == 0) begin
        #2 reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
      end else begin
        if (r < 3)       ins = INSTR_LOAD;
        else if (r < 9)  ins = INSTR_SETMODE;
        else if (r < 20) ins = 3'($urandom_range(0, 7));
        else             ins = INSTR_RUN;
        cyc(ins, 2'($urandom_range(0, 3)), 8'($urandom));
      end
    end

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
